// File: rtl/latch_capture_buf.sv
// Captures the held value of a transparent latch on each gate close and queues it in a FWFT FIFO.
// Optional two-flop input synchronizer enabled by defining LATCH_CAPTURE_SYNC_EN.
module latch_capture_buf #(
  parameter int N     = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gate_in,
  input  logic [N-1:0]               q_in,
  output logic [N-1:0]               dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic         g_s;
  logic [N-1:0] q_s;
  logic         g_d;

`ifdef LATCH_CAPTURE_SYNC_EN
  logic         g_s1, g_s2;
  logic [N-1:0] q_s1, q_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      g_s1 <= 1'b0;
      g_s2 <= 1'b0;
      q_s1 <= '0;
      q_s2 <= '0;
    end else begin
      g_s1 <= gate_in;
      g_s2 <= g_s1;
      q_s1 <= q_in;
      q_s2 <= q_s1;
    end
  end

  assign g_s = g_s2;
  assign q_s = q_s2;
`else
  logic         g_r;
  logic [N-1:0] q_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      g_r <= 1'b0;
      q_r <= '0;
    end else begin
      g_r <= gate_in;
      q_r <= q_in;
    end
  end

  assign g_s = g_r;
  assign q_s = q_r;
`endif

  // g_d resets low so a gate that was high across reset cannot fake a close.
  always_ff @(posedge clk) begin
    if (rst) g_d <= 1'b0;
    else     g_d <= g_s;
  end

  logic cap;
  assign cap = g_d & ~g_s;

  // Handshake: the head word transfers on any clk edge where dout_valid and
  // dout_ready are both high; dout_valid never depends on dout_ready.
  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, drop;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign dout_valid = ~empty;
  assign dout       = mem[rd_ptr];

  assign pop  = dout_valid & dout_ready;
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= q_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule
